svm_inference_pipe: RTL and testbench

//  Parametrised successor SVM decision engine for the fall-detection path. Linear-kernel decision

---
 rtl/svm_inference_pipe.sv | 161 ++++++++++++++++
 tb/tb_svm_inference_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_inference_pipe.sv
// Linear-kernel SVM decision engine: one support vector per cycle from external 1-cycle ROMs, saturating accumulator.
// Optional build macro SVM_SCORE_OUT_EN adds the registered 'score' output.
module svm_inference_pipe #(
   parameter int NUM_FEAT = 2,
   parameter int NUM_SV   = 5502,
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 16,
   parameter int ACC_W    = 48,
   parameter int ADDR_W   = 13
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NUM_FEAT*DATA_W-1:0]   feat_data,
   input  logic signed [DATA_W-1:0]     bias,
   output logic                         sv_rd_en,
   output logic [ADDR_W-1:0]            sv_addr,
   input  logic [NUM_FEAT*DATA_W-1:0]   sv_data,
   input  logic signed [DATA_W-1:0]     alpha_data,
   output logic                         busy,
   output logic                         done,
   output logic                         fall_detected
`ifdef SVM_SCORE_OUT_EN
   ,
   output logic signed [ACC_W-1:0]      score
`endif
);

   localparam int PROD_W  = 2 * DATA_W;
   localparam int PROD2_W = ACC_W + DATA_W;
   localparam int SUM_W   = PROD2_W + 1;
   localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(NUM_SV - 1);
   localparam logic signed [ACC_W-1:0]  ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [SUM_W-1:0]  SAT_HI    = SUM_W'(ACC_MAX);
   localparam logic signed [SUM_W-1:0]  SAT_LO    = SUM_W'(ACC_MIN);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

   function automatic logic signed [ACC_W-1:0] dot_fn(
      input logic [NUM_FEAT*DATA_W-1:0] f,
      input logic [NUM_FEAT*DATA_W-1:0] s
   );
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W-1:0]  sum;
      sum = '0;
      for (int i = 0; i < NUM_FEAT; i++) begin
         prod = PROD_W'($signed(f[i*DATA_W +: DATA_W])) * PROD_W'($signed(s[i*DATA_W +: DATA_W]));
         sum  = sum + ACC_W'(prod >>> FRAC_W);
      end
      return sum;
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
      if (v > SAT_HI)
         return ACC_MAX;
      else if (v < SAT_LO)
         return ACC_MIN;
      else
         return v[ACC_W-1:0];
   endfunction

   state_t                       state;
   logic                         accept;
   logic [NUM_FEAT*DATA_W-1:0]   feat_lat;
   logic signed [DATA_W-1:0]     bias_lat;
   logic                         vld_p0, vld_p1;
   logic signed [ACC_W-1:0]      dot_p1;
   logic signed [DATA_W-1:0]     alpha_p1;
   logic signed [ACC_W-1:0]      acc_p2;
   logic signed [PROD2_W-1:0]    prod2_c;
   logic signed [SUM_W-1:0]      sum_c;

   // Start is refused during the done cycle so a held request cannot retrigger.
   assign accept = (state == IDLE) && start && !done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         fall_detected <= 1'b0;
         sv_rd_en      <= 1'b0;
         sv_addr       <= '0;
         vld_p0        <= 1'b0;
         vld_p1        <= 1'b0;
      end else begin
         done   <= 1'b0;
         vld_p0 <= sv_rd_en;
         vld_p1 <= vld_p0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  sv_rd_en <= 1'b1;
                  sv_addr  <= '0;
               end
            end
            RUN: begin
               if (sv_addr == LAST_ADDR) begin
                  sv_rd_en <= 1'b0;
                  state    <= DRAIN;
               end else begin
                  sv_addr <= sv_addr + ADDR_W'(1);
               end
            end
            // The final row lands in acc on the same edge that leaves DRAIN.
            DRAIN: begin
               if (!vld_p0)
                  state <= FINISH;
            end
            FINISH: begin
               done          <= 1'b1;
               fall_detected <= acc_p2 > ACC_W'(bias_lat);
               busy          <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         feat_lat <= feat_data;
         bias_lat <= bias;
      end
   end

   // Stage 1: ROM row arrives with vld_p0; register the fixed-point dot product.
   always_ff @(posedge clk) begin
      dot_p1   <= dot_fn(feat_lat, sv_data);
      alpha_p1 <= alpha_data;
   end

   // Stage 2: scale by alpha and accumulate with saturation.
   assign prod2_c = PROD2_W'(dot_p1) * PROD2_W'(alpha_p1);
   assign sum_c   = SUM_W'(acc_p2) + SUM_W'(prod2_c >>> FRAC_W);

   always_ff @(posedge clk) begin
      if (reset)
         acc_p2 <= '0;
      else if (accept)
         acc_p2 <= '0;
      else if (vld_p1)
         acc_p2 <= sat_acc(sum_c);
   end

`ifdef SVM_SCORE_OUT_EN
   always_ff @(posedge clk) begin
      if (reset)
         score <= '0;
      else if (state == FINISH)
         score <= acc_p2;
   end
`else
   // Decision-only build: the accumulator stays internal.
`endif

endmodule

// File: tb/tb_svm_inference_pipe.sv
// Scoreboard bench for svm_inference_pipe with NUM_SV=4 and a 1-cycle ROM model.
module tb_svm_inference_pipe;

   localparam int NF = 2;
   localparam int NS = 4;
   localparam int DW = 32;
   localparam int FW = 16;
   localparam int AW = 48;
   localparam int ADW = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic [NF*DW-1:0]      feat_data = '0;
   logic signed [DW-1:0]  bias = '0;
   logic                  sv_rd_en;
   logic [ADW-1:0]        sv_addr;
   logic [NF*DW-1:0]      sv_data = '0;
   logic signed [DW-1:0]  alpha_data = '0;
   logic                  busy, done, fall_detected;
`ifdef SVM_SCORE_OUT_EN
   logic signed [AW-1:0]  score;
`endif

   svm_inference_pipe #(
      .NUM_FEAT(NF), .NUM_SV(NS), .DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .ADDR_W(ADW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .feat_data(feat_data), .bias(bias),
      .sv_rd_en(sv_rd_en), .sv_addr(sv_addr), .sv_data(sv_data), .alpha_data(alpha_data),
      .busy(busy), .done(done), .fall_detected(fall_detected)
`ifdef SVM_SCORE_OUT_EN
      , .score(score)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic last_fall = 1'b0;

   int sv0_mem [NS];
   int sv1_mem [NS];
   int alpha_mem [NS];
   int addr_log [$];

   logic              exp_fall [$];
   logic [AW-1:0]     exp_score [$];
   int                exp_cyc [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ROM model: row valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (sv_rd_en) begin
         sv_data    <= {sv1_mem[sv_addr], sv0_mem[sv_addr]};
         alpha_data <= alpha_mem[sv_addr];
         addr_log.push_back(int'(sv_addr));
      end
   end

   function automatic logic signed [AW-1:0] model_acc(input int f0, input int f1);
      logic signed [127:0] a, d, t, x0, x1, s0, s1, al;
      logic signed [AW-1:0] d48;
      logic signed [127:0] hi, lo;
      hi = 128'sh7FFF_FFFF_FFFF;
      lo = -hi - 128'sd1;
      a = '0;
      x0 = f0;
      x1 = f1;
      for (int k = 0; k < NS; k++) begin
         s0 = sv0_mem[k];
         s1 = sv1_mem[k];
         al = alpha_mem[k];
         d = ((x0 * s0) >>> FW) + ((x1 * s1) >>> FW);
         d48 = d[AW-1:0];
         d = d48;
         t = (d * al) >>> FW;
         a = a + t;
         if (a > hi) a = hi;
         if (a < lo) a = lo;
      end
      return a[AW-1:0];
   endfunction

   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_fall.size() == 0) begin
            chk("done_unexpected", 64'd1, 64'd0);
         end else begin
            chk("fall_detected", 64'(fall_detected), 64'(exp_fall[0]));
            chk("done_latency", 64'(cyc), 64'(exp_cyc[0]));
`ifdef SVM_SCORE_OUT_EN
            chk("score", 64'(score), 64'(exp_score[0]));
`endif
            void'(exp_fall.pop_front());
            void'(exp_score.pop_front());
            void'(exp_cyc.pop_front());
         end
      end
   end

   task automatic load_rom(input int s0, input int s1, input int al);
      for (int k = 0; k < NS; k++) begin
         sv0_mem[k] = s0;
         sv1_mem[k] = s1;
         alpha_mem[k] = al;
      end
   endtask

   task automatic start_run(input int f0, input int f1, input int b, input bit push);
      logic signed [AW-1:0] m;
      logic signed [AW-1:0] bx;
      @(negedge clk);
      feat_data = {f1, f0};
      bias = b;
      start = 1'b1;
      if (push) begin
         m = model_acc(f0, f1);
         bx = AW'(bias);
         exp_fall.push_back(m > bx);
         exp_score.push_back(m);
         exp_cyc.push_back(cyc + 8);
         last_fall = (m > bx);
      end
      @(negedge clk);
      start = 1'b0;
      feat_data = ~feat_data;
      bias = ~bias;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (exp_fall.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_fall.size() != 0) begin
         chk({tag, "_timeout"}, 64'(exp_fall.size()), 64'd0);
         exp_fall.delete();
         exp_score.delete();
         exp_cyc.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_fall", 64'(fall_detected), 64'd0);
      chk("rst_rd_en", 64'(sv_rd_en), 64'd0);
      chk("rst_addr", 64'(sv_addr), 64'd0);
`ifdef SVM_SCORE_OUT_EN
      chk("rst_score", 64'(score), 64'd0);
`endif

      // Basic decision, bias 11.0
      load_rom(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      start_run(32'h0001_0000, 32'h0002_0000, 32'h000B_0000, 1'b1);
      chk("busy_in_run", 64'(busy), 64'd1);
      wait_idle("bias11");
      repeat (3) @(negedge clk);
      chk("fall_hold", 64'(fall_detected), 64'(last_fall));
`ifdef SVM_SCORE_OUT_EN
      chk("score_12", 64'(score), 64'h0000_0000_000C_0000);
`endif

      // Strict compare at equality
      start_run(32'h0001_0000, 32'h0002_0000, 32'h000C_0000, 1'b1);
      wait_idle("bias12");

      // Negative alpha and bias
      load_rom(32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000);
      start_run(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 1'b1);
      wait_idle("neg");

      // Positive saturation
      load_rom(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      start_run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      wait_idle("sat");
`ifdef SVM_SCORE_OUT_EN
      chk("sat_score", 64'(score), 64'h0000_7FFF_FFFF_FFFF);
`endif

      // Negative saturation
      load_rom(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
      start_run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      wait_idle("negsat");

      // Mixed random rows
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NS; k++) begin
            sv0_mem[k] = int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
            sv1_mem[k] = int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
            alpha_mem[k] = int'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
         end
         start_run(int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000,
                   int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000,
                   int'($urandom_range(0, 32'h0002_0000)) - 32'sh0001_0000, 1'b1);
         wait_idle("rand");
      end

      // Starts during a run and in the done cycle are ignored
      load_rom(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      addr_log.delete();
      start_run(32'h0001_0000, 32'h0002_0000, 32'h000B_0000, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 64'(done), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", 64'(busy), 64'd0);
      repeat (10) @(negedge clk);
      chk("addr_count", 64'(addr_log.size()), 64'd4);
      for (int k = 0; k < addr_log.size() && k < 4; k++)
         chk("addr_seq", 64'(addr_log[k]), 64'(k));

      // Reset mid-run aborts without a done pulse
      start_run(32'h0001_0000, 32'h0002_0000, 32'h000B_0000, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rd_en", 64'(sv_rd_en), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      repeat (12) @(negedge clk);
      start_run(32'h0001_0000, 32'h0002_0000, 32'h000B_0000, 1'b1);
      wait_idle("after_abort");
`ifdef SVM_SCORE_OUT_EN
      chk("after_abort_score", 64'(score), 64'h0000_0000_000C_0000);
`endif

      repeat (4) @(negedge clk);
      chk("sb_empty", 64'(exp_fall.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
